// File: rtl/bldc_pkg.sv
// Shared state encoding, Gray step constants and the step-advance helper
// used by the BLDC quadrature generator.
package bldc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] STEP_0 = 2'b00;
  localparam logic [1:0] STEP_1 = 2'b01;
  localparam logic [1:0] STEP_2 = 2'b10;
  localparam logic [1:0] STEP_3 = 2'b11;

  // Counting up walks 00 -> 01 -> 11 -> 10 -> 00; counting down is the reverse.
  function automatic logic [1:0] nextStep(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    case (cur)
      STEP_0:  nxt = up ? STEP_1 : STEP_2;
      STEP_1:  nxt = up ? STEP_3 : STEP_0;
      STEP_3:  nxt = up ? STEP_2 : STEP_1;
      default: nxt = up ? STEP_0 : STEP_3;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bldc_step_timer.sv
// Reloadable down-counter that spaces quadrature edges; tick_o is high
// whenever the count sits at zero.
module bldc_step_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_i,
  input  logic                    run_i,
  input  logic [PERIOD_WIDTH-1:0] per_i,
  output logic                    tick_o
);

  localparam logic [PERIOD_WIDTH-1:0] ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  logic [PERIOD_WIDTH-1:0] per_q;
  logic [PERIOD_WIDTH-1:0] timer_q;

  // The period is captured on load so later reloads do not depend on the command bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_q   <= '0;
      timer_q <= '0;
    end else if (load_i) begin
      per_q   <= per_i;
      timer_q <= per_i - ONE;
    end else if (run_i) begin
      if (timer_q == '0) begin
        timer_q <= per_q - ONE;
      end else begin
        timer_q <= timer_q - ONE;
      end
    end
  end

  assign tick_o = (timer_q == '0);

endmodule

// File: rtl/bldc_quadrature_generator.sv
// Quadrature A/B waveform generator driven by a signed step command.
// Define QUAD_GEN_INDEX_EN to add the once-per-revolution index output.
module bldc_quadrature_generator
  import bldc_pkg::*;
#(
  parameter int STEP_WIDTH     = 16,
  parameter int PERIOD_WIDTH   = 16,
  parameter int COUNTER_WIDTH  = 15,
  parameter int COUNTS_PER_REV = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [STEP_WIDTH-1:0]    cmd_steps,
  input  logic [PERIOD_WIDTH-1:0]  cmd_period,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     abort,
  output logic [1:0]               enc,
  output logic [COUNTER_WIDTH-1:0] position,
  output logic                     busy,
  output logic                     done
`ifdef QUAD_GEN_INDEX_EN
  ,
  output logic                     index
`endif
);

  localparam logic [STEP_WIDTH-1:0]    STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_WIDTH-1:0]  PER_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] POS_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  if ((COUNTS_PER_REV & (COUNTS_PER_REV - 1)) != 0) begin : g_bad_cpr
    $error("COUNTS_PER_REV must be a power of two");
  end

  state_e                   state_q;
  logic [STEP_WIDTH-1:0]    remaining_q;
  logic                     dirUp_q;
  logic [1:0]               enc_q;
  logic [COUNTER_WIDTH-1:0] position_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     isNeg;
  logic [STEP_WIDTH-1:0]    magnitude;
  logic [PERIOD_WIDTH-1:0]  perClamped;
  logic                     load;
  logic                     tick;
  logic                     stepNow;
  logic [COUNTER_WIDTH-1:0] position_d;

  // Two's-complement negate of the most negative command still fits unsigned.
  assign isNeg      = cmd_steps[STEP_WIDTH-1];
  assign magnitude  = isNeg ? (~cmd_steps + STEP_ONE) : cmd_steps;
  assign perClamped = (cmd_period == '0) ? PER_ONE : cmd_period;
  assign load       = (state_q == IDLE) && cmd_valid && (cmd_steps != '0);
  assign stepNow    = (state_q == RUN) && tick;
  assign position_d = dirUp_q ? (position_q + POS_ONE) : (position_q - POS_ONE);

  bldc_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (load),
    .run_i  (state_q == RUN),
    .per_i  (perClamped),
    .tick_o (tick)
  );

  // A step coinciding with abort is still emitted before the command finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dirUp_q     <= 1'b0;
      enc_q       <= STEP_0;
      position_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_steps == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              remaining_q <= magnitude;
              dirUp_q     <= !isNeg;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          if (stepNow) begin
            enc_q       <= nextStep(enc_q, dirUp_q);
            position_q  <= position_d;
            remaining_q <= remaining_q - STEP_ONE;
          end
          if ((stepNow && (remaining_q == STEP_ONE)) || abort) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  localparam int IDX_BITS = $clog2(COUNTS_PER_REV);

  logic index_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= 1'b1;
    end else if (stepNow) begin
      index_q <= (position_d[IDX_BITS-1:0] == '0);
    end
  end

  assign index = index_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign enc       = enc_q;
  assign position  = position_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/bldc_quadrature_generator.md
# bldc_quadrature_generator

Generates a two-channel quadrature (A/B) encoder waveform from a commanded signed step count and step period. It is the transmit-side counterpart of the BLDC encoder counter. It emulates a motor encoder for hardware-in-the-loop checks of the BLDC drive path, and it drives the counter input directly in loopback self-test. Each emitted edge advances the sequence exactly one state, using the same up/down convention the counter decodes.

## Interface
- STEP_WIDTH, 16: width of the signed step command; the step magnitude is held unsigned at this width.
- PERIOD_WIDTH, 16: width of the step period, in clk cycles.
- COUNTER_WIDTH, 15: width of the emitted-position register.
- COUNTS_PER_REV, 4096: index spacing in counts; must be a power of two; used only when the index option is compiled in.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_steps  in  STEP_WIDTH  signed step count; positive counts up, negative counts down.
- cmd_period  in  PERIOD_WIDTH  clk cycles between edges; 0 is treated as 1.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high exactly when state is IDLE.
- abort  in  1  stops a running command at the next clock edge.
- enc  out  2  quadrature output, {B,A}; registered.
- position  out  COUNTER_WIDTH  net emitted steps; wraps modulo 2^COUNTER_WIDTH.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at command completion or abort.
- index  out  1  present only with the index option; see Configuration.

## Operation
- Up sequence: 00→01→11→10→00. Down sequence is the exact reverse. Exactly one enc bit changes per edge.
- States are IDLE, RUN and FINISH.
- IDLE:
  - A command is accepted when cmd_valid && cmd_ready.
  - If cmd_steps == 0, go to FINISH; enc does not change.
  - Otherwise, latch remaining = |cmd_steps|, dir = sign of cmd_steps, per = max(cmd_period, 1), and timer = per−1. Go to RUN.
  - cmd_steps = −2^(STEP_WIDTH−1) yields a magnitude of 2^(STEP_WIDTH−1); this must not overflow.
- RUN:
  - When timer == 0, enc steps once in dir, position moves ±1, remaining is decremented, and timer reloads to per−1.
  - When timer ≠ 0, timer is decremented.
  - When remaining reaches 0 on a step, go to FINISH.
  - cmd_valid is ignored in RUN.
- FINISH: done = 1 for one cycle, then go to IDLE.
- abort in RUN: go to FINISH on the next edge. enc and position keep their last completed step and never take a partial or skipped state. If abort and a step coincide, the step is emitted first.
- abort in IDLE or FINISH has no effect.
- Reset, including reset asserted mid-command: state = IDLE, enc = 00, position = 0, busy = 0, done = 0, cmd_ready = 1. Any command in flight is discarded.
- Position arithmetic is modulo 2^COUNTER_WIDTH: 0 − 1 gives all-ones, and all-ones + 1 gives 0.

## Timing
- For an accept on edge k, enc changes on edges k + per, k + 2·per, and so on. Edge spacing is exactly per cycles.
- done is high during the cycle after the edge that emits the final step. cmd_ready rises one cycle after done.
- A zero-step command: done is high one cycle after accept, and cmd_ready returns the cycle after that.
- Command-to-command throughput: the next accept can occur no sooner than 2 cycles after the final edge.

## Configuration
- QUAD_GEN_INDEX_EN defined:
  - Adds the index output, a register updated together with position.
  - index = 1 whenever position[log2(COUNTS_PER_REV)−1:0] == 0, in either direction. Its reset value is 1.
- QUAD_GEN_INDEX_EN undefined: the index port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package bldc_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - the Gray step constants STEP_0..STEP_3 = 00, 01, 10, 11;
  - a next-state function for the step (current enc, dir) → next enc.
- One sub-module, bldc_step_timer, holds the reloadable down-counter. It takes per and a load pulse, and outputs a tick whenever timer == 0.

## Test plan
- Reset, then steps = +4, period = 3: enc = 01, 11, 10, 00 at 3, 6, 9 and 12 cycles after accept. Final position = 4. done fires the cycle after the 4th edge.
- steps = −2, period = 0: enc = 10 then 11 on consecutive cycles. position = 0x7FFE (wrapped). busy is high for 2 cycles.
- steps = +100, period = 5, abort asserted after the 7th edge: no further edges. position = 7, one done pulse, then cmd_ready = 1.
- steps = 0: no enc change. done occurs 1 cycle after accept. cmd_valid held high during RUN of the next command is not re-accepted.
- reset_n pulsed low mid-command (steps = +50, after 10 edges): all outputs take their reset values immediately and asynchronously. After release, a new command starts from enc = 00.
- Loopback: enc drives the BLDC encoder counter with steps = +4096 then −4096, with QUAD_GEN_INDEX_EN defined. Counter and position agree at every step. index is high at position 0 and 4096 (mod 2^15).
